// File: rtl/vbuf_frame_scheduler.sv
// Write-side scheduler for the ping-pong frame buffers: chops each frame into DMA chunk
// descriptors, tracks completions, commits finished frames and arbitrates buffer locks with the reader.
module vbuf_frame_scheduler #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    LEN_WIDTH       = 32,
  parameter int                    TAG_WIDTH       = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR_A     = 32'h10000000,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR_B     = 32'h12000000,
  parameter int                    FRAME_BYTES     = 655360,
  parameter int                    CHUNK_BYTES     = 2048,
  parameter int                    MAX_OUTSTANDING = 4
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst_n,
  input  logic                  i_frame_start,
  input  logic                  i_chunk_avail,
  output logic [ADDR_WIDTH-1:0] s_axis_write_desc_addr,
  output logic [LEN_WIDTH-1:0]  s_axis_write_desc_len,
  output logic [TAG_WIDTH-1:0]  s_axis_write_desc_tag,
  output logic                  s_axis_write_desc_valid,
  input  logic                  s_axis_write_desc_ready,
  input  logic                  m_axis_write_desc_status_valid,
  input  logic                  i_rd_frame_req,
  input  logic                  i_rd_frame_done,
  output logic [ADDR_WIDTH-1:0] o_rd_buf_addr,
  output logic                  o_rd_grant,
  output logic                  o_rd_miss,
  output logic                  o_wr_buf_sel,
  output logic                  o_frame_done,
  output logic                  o_frame_drop,
  output logic                  o_overrun,
  output logic                  o_busy
);

  localparam int NUM_CHUNKS = FRAME_BYTES / CHUNK_BYTES;
  localparam int CNT_W      = $clog2(NUM_CHUNKS + 1);
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]      NUM_CHUNKS_C = CNT_W'(NUM_CHUNKS);
  localparam logic [OUT_W-1:0]      MAX_OUT_C    = OUT_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] CHUNK_STEP   = ADDR_WIDTH'(CHUNK_BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        issued_reg;
  logic [CNT_W-1:0]        done_reg;
  logic [OUT_W-1:0]        outstanding_reg;
  logic                    desc_valid_reg;
  logic [ADDR_WIDTH-1:0]   desc_addr_reg;
  logic [TAG_WIDTH-1:0]    desc_tag_reg;
  logic                    wr_buf_sel_reg;
  logic                    latest_reg;
  logic                    latest_valid_reg;
  logic                    rd_locked_reg;
  logic                    locked_idx_reg;
  logic [ADDR_WIDTH-1:0]   rd_buf_addr_reg;
  logic                    rd_grant_reg;
  logic                    rd_miss_reg;
  logic                    frame_done_reg;
  logic                    frame_drop_reg;
  logic                    overrun_reg;
  logic                    busy_reg;

  logic                    hs;
  logic                    st_eff;
  logic                    target;
  logic                    can_issue;
  logic [CNT_W-1:0]        issued_next;
  logic [CNT_W-1:0]        done_next;
  logic [OUT_W-1:0]        out_next;
  logic [ADDR_WIDTH-1:0]   addr_next;

  function automatic logic [ADDR_WIDTH-1:0] buf_base(input logic sel);
    return sel ? BASE_ADDR_B : BASE_ADDR_A;
  endfunction

  // Completions with nothing in flight are stray and must not corrupt the counters.
  always_comb begin
    hs          = desc_valid_reg && s_axis_write_desc_ready;
    st_eff      = m_axis_write_desc_status_valid && (outstanding_reg != '0);
    issued_next = issued_reg + CNT_W'(hs);
    done_next   = done_reg + CNT_W'(st_eff);
    out_next    = outstanding_reg + OUT_W'(hs) - OUT_W'(st_eff);
    target      = latest_valid_reg ? ~latest_reg : 1'b0;
    can_issue   = i_chunk_avail && (out_next < MAX_OUT_C) && (issued_next < NUM_CHUNKS_C);
    addr_next   = buf_base(wr_buf_sel_reg) + ADDR_WIDTH'(issued_next) * CHUNK_STEP;
  end

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      state_reg        <= IDLE;
      issued_reg       <= '0;
      done_reg         <= '0;
      outstanding_reg  <= '0;
      desc_valid_reg   <= 1'b0;
      desc_addr_reg    <= '0;
      desc_tag_reg     <= '0;
      wr_buf_sel_reg   <= 1'b0;
      latest_reg       <= 1'b0;
      latest_valid_reg <= 1'b0;
      rd_locked_reg    <= 1'b0;
      locked_idx_reg   <= 1'b0;
      rd_buf_addr_reg  <= BASE_ADDR_A;
      rd_grant_reg     <= 1'b0;
      rd_miss_reg      <= 1'b0;
      frame_done_reg   <= 1'b0;
      frame_drop_reg   <= 1'b0;
      overrun_reg      <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      frame_done_reg  <= 1'b0;
      frame_drop_reg  <= 1'b0;
      overrun_reg     <= 1'b0;
      rd_grant_reg    <= 1'b0;
      rd_miss_reg     <= 1'b0;
      outstanding_reg <= out_next;
      done_reg        <= done_next;

      case (state_reg)
        IDLE: begin
          if (i_frame_start) begin
            if (rd_locked_reg && (locked_idx_reg == target)) begin
              frame_drop_reg <= 1'b1;
            end else begin
              wr_buf_sel_reg <= target;
              issued_reg     <= '0;
              done_reg       <= '0;
              busy_reg       <= 1'b1;
              state_reg      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          overrun_reg <= i_frame_start;
          issued_reg  <= issued_next;
          // A presented descriptor is frozen until the DMA takes it.
          if (!desc_valid_reg || hs) begin
            desc_valid_reg <= can_issue;
            desc_addr_reg  <= addr_next;
            desc_tag_reg   <= TAG_WIDTH'(issued_next);
          end
          if (issued_next == NUM_CHUNKS_C) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          overrun_reg <= i_frame_start;
          if ((done_next == NUM_CHUNKS_C) && (out_next == '0)) begin
            latest_reg       <= wr_buf_sel_reg;
            latest_valid_reg <= 1'b1;
            frame_done_reg   <= 1'b1;
            busy_reg         <= 1'b0;
            state_reg        <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // A simultaneous release and request resolves to the request, so the lock is kept.
      if (i_rd_frame_req && latest_valid_reg) begin
        rd_buf_addr_reg <= buf_base(latest_reg);
        locked_idx_reg  <= latest_reg;
        rd_locked_reg   <= 1'b1;
        rd_grant_reg    <= 1'b1;
      end else if (i_rd_frame_done) begin
        rd_locked_reg <= 1'b0;
      end
      if (i_rd_frame_req && !latest_valid_reg) begin
        rd_miss_reg <= 1'b1;
      end
    end
  end

  assign s_axis_write_desc_addr  = desc_addr_reg;
  assign s_axis_write_desc_len   = LEN_WIDTH'(CHUNK_BYTES);
  assign s_axis_write_desc_tag   = desc_tag_reg;
  assign s_axis_write_desc_valid = desc_valid_reg;
  assign o_rd_buf_addr           = rd_buf_addr_reg;
  assign o_rd_grant              = rd_grant_reg;
  assign o_rd_miss               = rd_miss_reg;
  assign o_wr_buf_sel            = wr_buf_sel_reg;
  assign o_frame_done            = frame_done_reg;
  assign o_frame_drop            = frame_drop_reg;
  assign o_overrun               = overrun_reg;
  assign o_busy                  = busy_reg;

endmodule

// File: tb/tb_vbuf_frame_scheduler.sv
// Scoreboard bench for vbuf_frame_scheduler: stimulus queues expected descriptors and pulses,
// a monitor pops and compares them as the DUT presents them.
module tb_vbuf_frame_scheduler;

  localparam logic [31:0] BASE_A = 32'h10000000;
  localparam logic [31:0] BASE_B = 32'h12000000;
  localparam int EV_DONE = 1;
  localparam int EV_DROP = 2;
  localparam int EV_OVR  = 3;

  logic        axi_clk = 1'b0;
  logic        axi_rst_n;
  logic        i_frame_start;
  logic        i_chunk_avail;
  logic [31:0] s_axis_write_desc_addr;
  logic [31:0] s_axis_write_desc_len;
  logic [7:0]  s_axis_write_desc_tag;
  logic        s_axis_write_desc_valid;
  logic        s_axis_write_desc_ready;
  logic        m_axis_write_desc_status_valid;
  logic        i_rd_frame_req;
  logic        i_rd_frame_done;
  logic [31:0] o_rd_buf_addr;
  logic        o_rd_grant;
  logic        o_rd_miss;
  logic        o_wr_buf_sel;
  logic        o_frame_done;
  logic        o_frame_drop;
  logic        o_overrun;
  logic        o_busy;

  always #5 axi_clk = ~axi_clk;

  vbuf_frame_scheduler dut (
    .axi_clk                        (axi_clk),
    .axi_rst_n                      (axi_rst_n),
    .i_frame_start                  (i_frame_start),
    .i_chunk_avail                  (i_chunk_avail),
    .s_axis_write_desc_addr         (s_axis_write_desc_addr),
    .s_axis_write_desc_len          (s_axis_write_desc_len),
    .s_axis_write_desc_tag          (s_axis_write_desc_tag),
    .s_axis_write_desc_valid        (s_axis_write_desc_valid),
    .s_axis_write_desc_ready        (s_axis_write_desc_ready),
    .m_axis_write_desc_status_valid (m_axis_write_desc_status_valid),
    .i_rd_frame_req                 (i_rd_frame_req),
    .i_rd_frame_done                (i_rd_frame_done),
    .o_rd_buf_addr                  (o_rd_buf_addr),
    .o_rd_grant                     (o_rd_grant),
    .o_rd_miss                      (o_rd_miss),
    .o_wr_buf_sel                   (o_wr_buf_sel),
    .o_frame_done                   (o_frame_done),
    .o_frame_drop                   (o_frame_drop),
    .o_overrun                      (o_overrun),
    .o_busy                         (o_busy)
  );

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int cyc = 0;
  int base_hs;
  logic [31:0] last_addr = '0;
  logic rdy_en = 1'b1;
  logic stall = 1'b0;

  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_tag_q[$];
  int          ev_q[$];
  logic        rd_kind_q[$];
  logic [31:0] rd_addr_q[$];
  int          due_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic sel);
    logic [31:0] base;
    base = sel ? BASE_B : BASE_A;
    for (int i = 0; i < 320; i++) begin
      exp_addr_q.push_back(base + 32'(i) * 32'd2048);
      exp_tag_q.push_back(8'(i));
    end
  endtask

  task automatic pulse_frame_start();
    i_frame_start = 1'b1;
    @(negedge axi_clk);
    i_frame_start = 1'b0;
  endtask

  task automatic pulse_rd(input logic req, input logic done);
    i_rd_frame_req  = req;
    i_rd_frame_done = done;
    @(negedge axi_clk);
    i_rd_frame_req  = 1'b0;
    i_rd_frame_done = 1'b0;
    repeat (2) @(negedge axi_clk);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000 && o_busy; k++) @(negedge axi_clk);
    check("idle_timeout", o_busy, 1'b0);
    @(negedge axi_clk);
  endtask

  // DMA model: accepts while rdy_en, returns one status 2 cycles after each handshake unless stalled.
  initial begin
    s_axis_write_desc_ready        = 1'b0;
    m_axis_write_desc_status_valid = 1'b0;
    forever begin
      @(negedge axi_clk);
      cyc++;
      if (!axi_rst_n) begin
        due_q.delete();
        s_axis_write_desc_ready        = 1'b0;
        m_axis_write_desc_status_valid = 1'b0;
      end else begin
        s_axis_write_desc_ready = rdy_en;
        if (s_axis_write_desc_valid && rdy_en) due_q.push_back(cyc + 2);
        if (!stall && due_q.size() > 0 && due_q[0] <= cyc) begin
          void'(due_q.pop_front());
          m_axis_write_desc_status_valid = 1'b1;
        end else begin
          m_axis_write_desc_status_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: compares each presented output against the queued expectation.
  initial begin
    forever begin
      @(negedge axi_clk);
      #1;
      if (axi_rst_n) begin
        if (s_axis_write_desc_valid && s_axis_write_desc_ready) begin
          hs_cnt++;
          last_addr = s_axis_write_desc_addr;
          if (exp_addr_q.size() == 0) begin
            check("desc_unexpected", 1'b1, 1'b0);
          end else begin
            check("desc_addr", s_axis_write_desc_addr, exp_addr_q.pop_front());
            check("desc_tag", s_axis_write_desc_tag, exp_tag_q.pop_front());
            check("desc_len", s_axis_write_desc_len, 32'd2048);
          end
        end
        if (o_rd_grant || o_rd_miss) begin
          $display("rd %s addr=0x%08h", o_rd_grant ? "grant" : "miss", o_rd_buf_addr);
          if (rd_kind_q.size() == 0) begin
            check("rd_unexpected", 1'b1, 1'b0);
          end else begin
            logic        kind;
            logic [31:0] a;
            kind = rd_kind_q.pop_front();
            a    = rd_addr_q.pop_front();
            check("rd_grant", o_rd_grant, kind);
            check("rd_miss", o_rd_miss, !kind);
            if (kind) check("rd_addr", o_rd_buf_addr, a);
          end
        end
        if (o_frame_done || o_frame_drop || o_overrun) begin
          int code;
          code = o_frame_done ? EV_DONE : (o_frame_drop ? EV_DROP : EV_OVR);
          $display("event code=%0d sel=%0d", code, o_wr_buf_sel);
          if (ev_q.size() == 0) check("event_unexpected", 64'(code), 64'd0);
          else check("event_code", 64'(code), 64'(ev_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    axi_rst_n       = 1'b0;
    i_frame_start   = 1'b0;
    i_chunk_avail   = 1'b0;
    i_rd_frame_req  = 1'b0;
    i_rd_frame_done = 1'b0;
    repeat (3) @(negedge axi_clk);
    check("rst_valid", s_axis_write_desc_valid, 1'b0);
    check("rst_addr", s_axis_write_desc_addr, 32'h0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_rd_addr", o_rd_buf_addr, BASE_A);
    check("rst_wr_sel", o_wr_buf_sel, 1'b0);
    check("rst_pulses", {o_rd_grant, o_rd_miss, o_frame_done, o_frame_drop, o_overrun}, 5'b0);
    axi_rst_n = 1'b1;
    @(negedge axi_clk);

    rd_kind_q.push_back(1'b0); rd_addr_q.push_back(32'h0);
    pulse_rd(1'b1, 1'b0);

    // Frame 1 with status stalled: only 4 descriptors may fly.
    stall = 1'b1;
    i_chunk_avail = 1'b1;
    push_frame(1'b0);
    base_hs = hs_cnt;
    pulse_frame_start();
    repeat (20) @(negedge axi_clk);
    check("stall_count", 64'(hs_cnt - base_hs), 64'd4);
    check("stall_valid", s_axis_write_desc_valid, 1'b0);
    check("stall_busy", o_busy, 1'b1);
    rdy_en = 1'b0;
    stall  = 1'b0;
    for (int k = 0; k < 20 && !s_axis_write_desc_valid; k++) @(negedge axi_clk);
    check("hold_valid", s_axis_write_desc_valid, 1'b1);
    check("hold_addr", s_axis_write_desc_addr, 32'h10002000);
    i_chunk_avail = 1'b0;
    repeat (3) @(negedge axi_clk);
    check("hold_valid_noavail", s_axis_write_desc_valid, 1'b1);
    check("hold_addr_noavail", s_axis_write_desc_addr, 32'h10002000);
    check("hold_tag_noavail", s_axis_write_desc_tag, 8'd4);
    i_chunk_avail = 1'b1;
    rdy_en = 1'b1;
    for (int k = 0; k < 1000 && (hs_cnt - base_hs) < 100; k++) @(negedge axi_clk);
    ev_q.push_back(EV_OVR);
    pulse_frame_start();
    ev_q.push_back(EV_DONE);
    wait_idle();
    $display("frame1 descriptors=%0d last=0x%08h", hs_cnt - base_hs, last_addr);
    check("f1_count", 64'(hs_cnt - base_hs), 64'd320);
    check("f1_last_addr", last_addr, 32'h1009F800);
    check("f1_sb_empty", 64'(exp_addr_q.size()), 64'd0);

    rd_kind_q.push_back(1'b1); rd_addr_q.push_back(BASE_A);
    pulse_rd(1'b1, 1'b0);

    // Frame 2 goes to buffer 1 while the reader holds buffer 0.
    push_frame(1'b1);
    ev_q.push_back(EV_DONE);
    base_hs = hs_cnt;
    pulse_frame_start();
    wait_idle();
    $display("frame2 descriptors=%0d last=0x%08h", hs_cnt - base_hs, last_addr);
    check("f2_sel", o_wr_buf_sel, 1'b1);
    check("f2_last_addr", last_addr, 32'h1209F800);

    // Frame 3 targets the locked buffer 0 and must be dropped.
    ev_q.push_back(EV_DROP);
    base_hs = hs_cnt;
    pulse_frame_start();
    repeat (5) @(negedge axi_clk);
    $display("frame3 dropped descriptors=%0d", hs_cnt - base_hs);
    check("drop_no_desc", 64'(hs_cnt - base_hs), 64'd0);
    check("drop_idle", o_busy, 1'b0);

    pulse_rd(1'b0, 1'b1);
    push_frame(1'b0);
    ev_q.push_back(EV_DONE);
    base_hs = hs_cnt;
    pulse_frame_start();
    wait_idle();
    $display("frame3 retry descriptors=%0d last=0x%08h", hs_cnt - base_hs, last_addr);
    check("f3_sel", o_wr_buf_sel, 1'b0);
    check("f3_count", 64'(hs_cnt - base_hs), 64'd320);

    rd_kind_q.push_back(1'b1); rd_addr_q.push_back(BASE_A);
    pulse_rd(1'b1, 1'b0);

    // Frame 4 is cut short by reset.
    push_frame(1'b1);
    base_hs = hs_cnt;
    pulse_frame_start();
    for (int k = 0; k < 500 && (hs_cnt - base_hs) < 50; k++) @(negedge axi_clk);
    axi_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", s_axis_write_desc_valid, 1'b0);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_sel", o_wr_buf_sel, 1'b0);
    check("mid_rst_rd_addr", o_rd_buf_addr, BASE_A);
    exp_addr_q.delete();
    exp_tag_q.delete();
    repeat (2) @(negedge axi_clk);
    axi_rst_n = 1'b1;
    @(negedge axi_clk);
    rd_kind_q.push_back(1'b0); rd_addr_q.push_back(32'h0);
    pulse_rd(1'b1, 1'b0);

    repeat (2) @(negedge axi_clk);
    check("ev_q_empty", 64'(ev_q.size()), 64'd0);
    check("rd_q_empty", 64'(rd_kind_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
